// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-client RAM arbiter: owner encoding,
// client identifiers, burst default and the burst counter sizing helper.
package mem_arb_pkg;

  // Current owner of the RAM port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  // Identifies a client; used for the last-served pointer.
  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  // Longest run of grants to one client while the other one waits.
  localparam int MAX_BURST_DEFAULT = 8;

  // Counter width able to hold the values 0..max_burst inclusive.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin grant decision with owner hold. Purely combinational:
// the owner keeps the port while it requests, until its burst counter is
// full and the other client is waiting. Otherwise the client that was not
// served last wins a tie.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int CNT_W     = cnt_width(MAX_BURST)
) (
  input  logic             a_req,
  input  logic             b_req,
  input  logic [1:0]       owner,
  input  logic [CNT_W-1:0] cnt,
  input  logic             last_b,
  output logic             gnt_a,
  output logic             gnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic burst_done;

  assign burst_done = (cnt == CNT_MAX);

  // Grant selection: owner hold first, then fairness between two requesters.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (owner == OWN_A && a_req) begin
      if (burst_done && b_req) gnt_b = 1'b1;
      else                     gnt_a = 1'b1;
    end else if (owner == OWN_B && b_req) begin
      if (burst_done && a_req) gnt_a = 1'b1;
      else                     gnt_b = 1'b1;
    end else if (a_req && b_req) begin
      if (last_b) gnt_a = 1'b1;
      else        gnt_b = 1'b1;
    end else begin
      gnt_a = a_req;
      gnt_b = b_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one RAM (one write port, two read ports, 1-cycle read
// latency) between clients A and B. Grants are combinational; the read
// return is tagged with a registered per-client rvalid, and the shared
// rd_data outputs hold the last returned words between returns.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // client A
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_waddr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [ADDR_WIDTH-1:0] a_raddr_1,
  input  logic [ADDR_WIDTH-1:0] a_raddr_2,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  // client B
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_waddr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [ADDR_WIDTH-1:0] b_raddr_1,
  input  logic [ADDR_WIDTH-1:0] b_raddr_2,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  // shared read return
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2,
  // RAM side
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr_1,
  output logic [ADDR_WIDTH-1:0] mem_read_addr_2,
  input  logic [DATA_WIDTH-1:0] mem_read_data_1,
  input  logic [DATA_WIDTH-1:0] mem_read_data_2,
  output logic                  busy
);

  localparam int               CNT_W   = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  owner_e                owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  client_e               last_q, last_d;
  logic                  pick_a, pick_b;
  logic                  any_rvalid;
  logic [DATA_WIDTH-1:0] rd_hold_1, rd_hold_2;

  rr_pick2 #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .a_req  (a_req),
    .b_req  (b_req),
    .owner  (owner_q),
    .cnt    (cnt_q),
    .last_b (last_q == CLIENT_B),
    .gnt_a  (pick_a),
    .gnt_b  (pick_b)
  );

  // Reset is synchronous, so the combinational grants are masked while it
  // is asserted to keep the RAM untouched during reset.
  assign a_gnt = pick_a & rst_n;
  assign b_gnt = pick_b & rst_n;
  assign busy  = a_gnt | b_gnt;

  // Next owner, burst count and last-served pointer from this cycle's grant.
  always_comb begin
    owner_d = IDLE;
    cnt_d   = '0;
    last_d  = last_q;
    if (a_gnt) begin
      owner_d = OWN_A;
      last_d  = CLIENT_A;
      if (owner_q != OWN_A)    cnt_d = CNT_ONE;
      else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                     cnt_d = cnt_q + CNT_ONE;
    end else if (b_gnt) begin
      owner_d = OWN_B;
      last_d  = CLIENT_B;
      if (owner_q != OWN_B)    cnt_d = CNT_ONE;
      else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                     cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Ownership state register; reset leaves B as last served so A wins first.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!rst_n) begin
      owner_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= CLIENT_B;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Route the granted client's access onto the RAM port; all zero when idle.
  always_comb begin
    mem_write_en    = 1'b0;
    mem_write_addr  = '0;
    mem_write_data  = '0;
    mem_read_addr_1 = '0;
    mem_read_addr_2 = '0;
    if (a_gnt) begin
      mem_write_en    = a_we;
      mem_write_addr  = a_waddr;
      mem_write_data  = a_wdata;
      mem_read_addr_1 = a_raddr_1;
      mem_read_addr_2 = a_raddr_2;
    end else if (b_gnt) begin
      mem_write_en    = b_we;
      mem_write_addr  = b_waddr;
      mem_write_data  = b_wdata;
      mem_read_addr_1 = b_raddr_1;
      mem_read_addr_2 = b_raddr_2;
    end
  end

  // Read return tagging: rvalid follows the grant by one cycle, and the
  // returned words are captured so rd_data holds them afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      rd_hold_1 <= '0;
      rd_hold_2 <= '0;
    end else begin
      a_rvalid <= a_gnt;
      b_rvalid <= b_gnt;
      if (any_rvalid) begin
        rd_hold_1 <= mem_read_data_1;
        rd_hold_2 <= mem_read_data_2;
      end
    end
  end

  // The RAM already registers its read data, so in the return cycle it is
  // passed straight through; no same-cycle write forwarding is attempted.
  assign any_rvalid = a_rvalid | b_rvalid;
  assign rd_data_1  = any_rvalid ? mem_read_data_1 : rd_hold_1;
  assign rd_data_2  = any_rvalid ? mem_read_data_2 : rd_hold_2;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 4, as the RAM address width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 16, as the RAM word width.
REQ-003 The block SHALL expose parameter MAX_BURST, default 8, as the maximum number of consecutive grants to one client while the other client waits.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 a_req / b_req  in  1  client requests one RAM access this cycle.
REQ-008 a_we / b_we  in  1  the access includes a write.
REQ-009 a_waddr / b_waddr  in  ADDR_WIDTH  write address.
REQ-010 a_wdata / b_wdata  in  DATA_WIDTH  write data.
REQ-011 a_raddr_1, a_raddr_2 / b_raddr_1, b_raddr_2  in  ADDR_WIDTH  read addresses for the two read ports.
REQ-012 a_gnt / b_gnt  out  1  access accepted this cycle (combinational).
REQ-013 a_rvalid / b_rvalid  out  1  rd_data_1/rd_data_2 belong to this client (registered).
REQ-014 rd_data_1, rd_data_2  out  DATA_WIDTH  shared read return data.
REQ-015 mem_write_en  out  1; mem_write_addr  out  ADDR_WIDTH; mem_write_data  out  DATA_WIDTH  RAM write port.
REQ-016 mem_read_addr_1, mem_read_addr_2  out  ADDR_WIDTH  RAM read addresses.
REQ-017 mem_read_data_1, mem_read_data_2  in  DATA_WIDTH  RAM read data, valid one clk cycle after the address.
REQ-018 busy  out  1  high in any cycle with a grant.

Function
REQ-019 At most one of a_gnt, b_gnt SHALL be high per cycle, and a grant SHALL only be given to a requesting client.
REQ-020 Owner state SHALL be one of IDLE, OWN_A, OWN_B, with cnt counting consecutive grants to the current owner, saturating at MAX_BURST.
REQ-021 In IDLE, or when the owner's req is low, a single requester SHALL be granted, and with two requesters the client not served last SHALL be granted.
REQ-022 The owner SHALL keep the grant while its req is high, unless cnt==MAX_BURST and the other client requests, in which case the other client SHALL be granted that cycle.
REQ-023 A grant SHALL set the owner to the granted client, with cnt=1 on owner change or cnt+1 (saturating) otherwise; a cycle with no grant SHALL set IDLE with cnt=0.
REQ-024 The last-served pointer SHALL update to the granted client on every grant.
REQ-025 In a granted cycle, mem_read_addr_1/2 SHALL equal the granted client's raddr_1/2, and mem_write_en SHALL equal its we, with waddr/wdata passed through.
REQ-026 In a cycle without a grant, mem_write_en SHALL be 0 and all mem address and data outputs SHALL be 0.
REQ-027 x_rvalid SHALL be high exactly one cycle after x_gnt, and in that cycle rd_data_1/2 SHALL equal mem_read_data_1/2; otherwise rd_data SHALL hold its last value.
REQ-028 Read latency SHALL be 1 cycle, and back-to-back grants SHALL give one result per cycle.
REQ-029 A read and a write to the same address in one granted cycle SHALL NOT be forwarded, and the returned value SHALL be whatever the RAM produces.

Reset
REQ-030 While rst_n==0 at a clk edge, the block SHALL set owner IDLE, cnt 0, last-served B, a_rvalid=b_rvalid=0 and rd_data_1=rd_data_2=0.
REQ-031 While rst_n==0, a_gnt, b_gnt, busy and mem_write_en SHALL be 0.
REQ-032 A reset mid-burst SHALL discard ownership and any pending rvalid.

Structure
REQ-033 A shared package mem_arb_pkg SHALL hold the owner state encoding (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2) and the MAX_BURST default.
REQ-034 The grant decision SHALL be a sub-module rr_pick2 (combinational two-way round-robin with owner hold), with the RAM instantiated outside this block.

Verification
REQ-035 The bench SHALL reset, then drive a_req=1, we=1, waddr=3, wdata=16'hBEEF, followed next cycle by a read at raddr_1=3, and check a_gnt each cycle, a_rvalid one cycle after the read, and rd_data_1=16'hBEEF.
REQ-036 The bench SHALL raise a_req and b_req together from reset and check that A is granted first (last-served=B), then A continuously for 8 cycles, then B in cycle 9.
REQ-037 The bench SHALL hold a_req high alone for 20 cycles and check a_gnt high every cycle with cnt saturated at 8 and no gaps.
REQ-038 The bench SHALL run a B burst, drop b_req for one cycle while a_req is high, and check that A is granted that same cycle with b_rvalid pulsing for B's last access.
REQ-039 The bench SHALL assert rst_n=0 during an A burst with a read issued the prior cycle and check a_rvalid=0, gnt=0 and rd_data=0 on the next edge.
REQ-040 The bench SHALL run 1000 cycles of random req/we traffic and check one-hot grants, mem_write_en=0 when idle, and every gnt followed by exactly one matching rvalid.
